// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// UartRx: 8N1 UART receiver with 16x oversampling and a one-deep holding
// register.
//
// Parameters
//   BAUD_DIV     clk cycles per 16x oversample tick (bit = 16*BAUD_DIV clk)
//
// Ports
//   clk          single clock, rising-edge
//   rst          asynchronous, active-high reset
//   rx_i         serial line, idle high, LSB first, asynchronous to clk
//   data_o       received byte in the holding register
//   valid_o      holding register holds an unconsumed byte
//   ready_i      consumer accepts data when valid_o && ready_i
//   frame_err_o  sticky: a stop bit was sampled low
//   overrun_o    sticky: a completed byte was dropped (holding register full)
//   clr_err_i    single-cycle pulse clearing both sticky flags
//   irq_o        one-cycle pulse per byte loaded into the holding register
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_err_i,
    output logic       irq_o
);

    localparam int TickW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             rxMeta_q;
    logic             rxSync_q;
    logic [TickW-1:0] tickCnt_q, tickCnt_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [3:0]       sampleCnt_q, sampleCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;
    logic             irq_q, irq_d;
    logic             stopSample;

    // Two-flop synchronizer; both flops reset to the idle (high) line level so
    // that reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
        end
    end

    // Free-running oversample tick generator.
    assign tick      = (tickCnt_q == TickMax);
    assign tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt_q   <= '0;
            state_q     <= IDLE;
            sampleCnt_q <= 4'd0;
            bitIdx_q    <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tickCnt_q   <= tickCnt_d;
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frameErr_q  <= frameErr_d;
            overrun_q   <= overrun_d;
            irq_q       <= irq_d;
        end
    end

    // Next-state logic for the frame FSM, holding register and sticky flags.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        irq_d       = 1'b0;
        stopSample  = 1'b0;
        // Clear first so that a flag setting in the same cycle wins.
        frameErr_d  = clr_err_i ? 1'b0 : frameErr_q;
        overrun_d   = clr_err_i ? 1'b0 : overrun_q;

        unique case (state_q)
            IDLE: begin
                if (tick && !rxSync_q) begin
                    state_d     = START;
                    sampleCnt_d = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    // Mid start bit: a high line means the low was a glitch.
                    if (sampleCnt_q == 4'd7) begin
                        if (rxSync_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = DATA;
                            sampleCnt_d = 4'd0;
                            bitIdx_d    = 3'd0;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sampleCnt_d = sampleCnt_q + 4'd1;
                    if (sampleCnt_q == 4'd15) begin
                        shift_d[bitIdx_q] = rxSync_q;
                        if (bitIdx_q == 3'd7) begin
                            state_d     = STOP;
                            sampleCnt_d = 4'd0;
                        end else begin
                            bitIdx_d = bitIdx_q + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sampleCnt_d = sampleCnt_q + 4'd1;
                    if (sampleCnt_q == 4'd15) begin
                        state_d    = IDLE;
                        stopSample = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // A byte may load when the register is empty or being drained this cycle.
        if (stopSample) begin
            if (rxSync_q) begin
                if (!valid_q || ready_i) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    irq_d   = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frameErr_d = 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// Directed testbench for uart_rx with BAUD_DIV=1 (one bit = 16 clk cycles).
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic       clrErr;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       overrun;
    logic       irq;

    int errors = 0;
    int checks = 0;

    // Cycle counter and an irq log (data present at each irq pulse, and when).
    int         cyc = 0;
    logic [7:0] irqLog[$];
    int         irqCyc[$];

    uart_rx #(.BAUD_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .frame_err_o(frameErr),
        .overrun_o  (overrun),
        .clr_err_i  (clrErr),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irq) begin
            irqLog.push_back(data);
            irqCyc.push_back(cyc);
        end
    end

    // Advance n cycles, landing just after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        step(16);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stopBit);
        rx = 1'b1;
    endtask

    task automatic pulseReady();
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    task automatic pulseClr();
        clrErr = 1'b1;
        step(1);
        clrErr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b0; clrErr = 1'b0;
        step(3);
        checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frameErr); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
        rst = 1'b0;
        step(5);
    endtask

    task automatic test_basic_rx();
        int base;
        int startCyc;
        base = irqLog.size();
        startCyc = cyc;
        sendFrame(8'hA5, 1'b1);
        step(4);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL a5_valid got=%b exp=1", valid); end
        checks++; if (data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data got=%h exp=a5", data); end
        checks++; if (irqLog.size() - base !== 1) begin errors++; $display("[TB] FAIL a5_irq_count got=%0d exp=1", irqLog.size() - base); end
        // 2 sync + 1 detect + 152 ticks to stop sample, irq on the following edge.
        if (irqLog.size() > base) begin
            checks++; if (irqCyc[base] - startCyc !== 155) begin errors++; $display("[TB] FAIL a5_latency got=%0d exp=155", irqCyc[base] - startCyc); end
        end
        checks++; if ({frameErr, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL a5_flags got=%b exp=00", {frameErr, overrun}); end
        step(3);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL a5_hold got=%b exp=1", valid); end
        pulseReady();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL a5_consume got=%b exp=0", valid); end
    endtask

    task automatic test_glitch();
        int base;
        base = irqLog.size();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid got=%b exp=0", valid); end
        checks++; if (irqLog.size() - base !== 0) begin errors++; $display("[TB] FAIL glitch_irq got=%0d exp=0", irqLog.size() - base); end
        checks++; if ({frameErr, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL glitch_flags got=%b exp=00", {frameErr, overrun}); end
        sendFrame(8'h3C, 1'b1);
        step(4);
        checks++; if ({valid, data} !== {1'b1, 8'h3C}) begin errors++; $display("[TB] FAIL after_glitch got=%b/%h exp=1/3c", valid, data); end
        pulseReady();
        step(2);
    endtask

    task automatic test_frame_err();
        int base;
        base = irqLog.size();
        sendFrame(8'h3C, 1'b0);
        step(20);
        checks++; if (frameErr !== 1'b1) begin errors++; $display("[TB] FAIL ferr_set got=%b exp=1", frameErr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ferr_valid got=%b exp=0", valid); end
        checks++; if (irqLog.size() - base !== 0) begin errors++; $display("[TB] FAIL ferr_irq got=%0d exp=0", irqLog.size() - base); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ferr_overrun got=%b exp=0", overrun); end
        pulseClr();
        checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clear got=%b exp=0", frameErr); end
    endtask

    task automatic test_overrun();
        int base;
        base = irqLog.size();
        ready = 1'b0;
        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
        step(4);
        checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL ovr_data got=%h exp=11", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid got=%b exp=1", valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (irqLog.size() - base !== 1) begin errors++; $display("[TB] FAIL ovr_irq got=%0d exp=1", irqLog.size() - base); end
        checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL ovr_ferr got=%b exp=0", frameErr); end
        pulseReady();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_consume got=%b exp=0", valid); end
        // ready while nothing is held must not disturb anything.
        ready = 1'b1;
        step(5);
        ready = 1'b0;
        checks++; if ({valid, data} !== {1'b0, 8'h11}) begin errors++; $display("[TB] FAIL idle_ready got=%b/%h exp=0/11", valid, data); end
        pulseClr();
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = irqLog.size();
        ready = 1'b1;
        sendFrame(8'h55, 1'b1);
        sendFrame(8'hAA, 1'b1);
        step(4);
        ready = 1'b0;
        checks++; if (irqLog.size() - base !== 2) begin errors++; $display("[TB] FAIL b2b_irq got=%0d exp=2", irqLog.size() - base); end
        if (irqLog.size() - base >= 2) begin
            checks++; if (irqLog[base] !== 8'h55) begin errors++; $display("[TB] FAIL b2b_first got=%h exp=55", irqLog[base]); end
            checks++; if (irqLog[base+1] !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_second got=%h exp=aa", irqLog[base+1]); end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got=%b exp=0", overrun); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got=%b exp=0", valid); end
    endtask

    task automatic test_reset_midframe();
        int base;
        ready = 1'b0;
        sendFrame(8'h5A, 1'b1);
        step(4);
        sendFrame(8'h00, 1'b0);
        step(20);
        checks++; if ({valid, frameErr, data} !== {1'b1, 1'b1, 8'h5A}) begin errors++; $display("[TB] FAIL pre_rst got=%b%b/%h exp=11/5a", valid, frameErr, data); end
        // Start 0x0F and stop part way through bit 3.
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b1);
        rx = 1'b1;
        step(8);
        rst = 1'b1;
        #1;
        checks++; if ({data, valid, frameErr, overrun, irq} !== 12'h000) begin errors++; $display("[TB] FAIL midrst_outputs got=%h/%b%b%b%b exp=00/0000", data, valid, frameErr, overrun, irq); end
        step(3);
        rst = 1'b0;
        step(5);
        base = irqLog.size();
        sendFrame(8'h0F, 1'b1);
        step(4);
        checks++; if ({valid, data} !== {1'b1, 8'h0F}) begin errors++; $display("[TB] FAIL post_rst got=%b/%h exp=1/0f", valid, data); end
        checks++; if (irqLog.size() - base !== 1) begin errors++; $display("[TB] FAIL post_rst_irq got=%0d exp=1", irqLog.size() - base); end
    endtask

    initial begin
        test_reset();
        test_basic_rx();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
